// File: rtl/sort_display_scan_if.sv
// Sorter-to-display bus: the sorter's completion level plus its four sorted values.
interface sort_display_scan_if #(
  parameter int DIGIT = 4
);
  logic             done;
  logic [DIGIT-1:0] s0;
  logic [DIGIT-1:0] s1;
  logic [DIGIT-1:0] s2;
  logic [DIGIT-1:0] s3;

  modport master (output done, s0, s1, s2, s3);
  modport slave  (input  done, s0, s1, s2, s3);
endinterface

// File: rtl/sort_display_scan.sv
// Snapshots the sorter's four results on done's rising edge and scans them as hex
// digits onto a 4-digit active-low 7-segment display, flagging non-decreasing order.
module sort_display_scan #(
  parameter int DIGIT    = 4,
  parameter int SCAN_DIV = 16,
  parameter int CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  sort_display_scan_if.slave sbus,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               latched,
  output logic               sorted_ok
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]       SEG_DASH = 7'b0111111;

  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [1:0]         slot_reg, slot_next;
  logic               done_d_reg;
  logic               latched_reg;
  logic               sorted_ok_reg;
  logic [3:0]         an_reg, an_next;
  logic [6:0]         seg_reg, seg_next;
  logic [3:0]         d_reg [4];
  logic [3:0]         s_ext [4];
  logic [4*DIGIT-1:0] s_flat;
  logic               wrap;
  logic               capture;
  logic               in_order;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'ha: hex7 = 7'b0001000;
      4'hb: hex7 = 7'b0000011;
      4'hc: hex7 = 7'b1000110;
      4'hd: hex7 = 7'b0100001;
      4'he: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign s_flat = {sbus.s3, sbus.s2, sbus.s1, sbus.s0};

  // Narrow values are zero-extended so the decoder always sees a full nibble.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ext
    assign s_ext[gi] = 4'(s_flat[gi*DIGIT +: DIGIT]);
  end

  assign wrap     = (cnt_reg == DIV_LAST);
  assign capture  = sbus.done & ~done_d_reg;
  assign in_order = (sbus.s0 <= sbus.s1) & (sbus.s1 <= sbus.s2) & (sbus.s2 <= sbus.s3);

  always_comb begin
    cnt_next  = wrap ? '0 : cnt_reg + CNT_W'(1);
    slot_next = wrap ? slot_reg + 2'd1 : slot_reg;
    an_next   = (cnt_reg == '0) ? 4'b1111 : ~(4'b0001 << slot_reg);
    seg_next  = latched_reg ? hex7(d_reg[slot_reg]) : SEG_DASH;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg       <= '0;
      slot_reg      <= '0;
      done_d_reg    <= 1'b0;
      latched_reg   <= 1'b0;
      sorted_ok_reg <= 1'b0;
      an_reg        <= 4'b1111;
      seg_reg       <= 7'b1111111;
      for (int i = 0; i < 4; i++) d_reg[i] <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      slot_reg   <= slot_next;
      done_d_reg <= sbus.done;
      an_reg     <= an_next;
      seg_reg    <= seg_next;
      // A level held high only captures once; done must drop before the next snapshot.
      if (capture) begin
        latched_reg   <= 1'b1;
        sorted_ok_reg <= in_order;
        for (int i = 0; i < 4; i++) d_reg[i] <= s_ext[i];
      end
    end
  end

  assign an        = an_reg;
  assign seg       = seg_reg;
  assign latched   = latched_reg;
  assign sorted_ok = sorted_ok_reg;

endmodule
